data_mem_io: RTL and testbench
==============================

# data_mem_io

Parametrised data memory and memory-mapped I/O unit for the single-cycle/multicycle CPU datapath. It sits between the core's load/store stage and the board peripherals. It extends the previous data-memory block with:
- a req/ack handshake and true byte-lane stores;
- misaligned-access detection;
- configurable RAM depth and LED/switch channel counts;
- synchronised switch inputs and sticky button-edge capture.

## Interface
- DEPTH_WORDS, 4096: RAM depth in 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- LED_CH, 2: number of 16-bit LED output registers.
- SW_CH, 2: number of 16-bit switch input channels.
- BTN_W, 5: number of push-button inputs.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- sign  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the used bits are right-aligned.
- rdata  out  32  load result; valid while ack = 1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid with ack.
- sw_in  in  SW_CH*16  raw switch inputs; channel i is bits [16i+15:16i].
- btn_in  in  BTN_W  raw button inputs.
- led_out  out  LED_CH*16  LED registers; channel i is bits [16i+15:16i].

## Operation
Address map:
- addr[31] = 0 selects RAM. The word index is addr[AW+1:2]; the upper bits are ignored, so accesses wrap modulo the depth.
- addr[31] = 1 selects I/O at offset addr[7:0]:
  - 0x00 + 4i: LED channel i, read/write.
  - 0x40 + 4i: switch channel i, read-only, returns the synchronised value.
  - 0x80: button level, read-only, synchronised.
  - 0x84: button sticky edges, read-only; a read clears the register.
  - Any other offset is unmapped.

Alignment:
- Halfword requires addr[0] = 0.
- Word requires addr[1:0] = 0.
- size = 3 is always an error.
- On an error there is no state change, rdata = 0 and err = 1.

Stores:
- RAM uses byte enables. Only the addressed lanes change: byte lane addr[1:0], half lanes {addr[1],0..1}. Data comes from wdata[7:0] or wdata[15:0], replicated to the addressed lane.
- LED stores update only lanes 0-1 of the 16-bit register; writes to lanes 2-3 are ignored.
- Stores to read-only I/O are ignored with err = 0.
- Any access to an unmapped offset gives err = 1.

Loads:
- The addressed lane is extracted and then sign- or zero-extended according to sign.
- I/O registers are zero-padded to 32 bits before lane extraction.

Input conditioning:
- Switches and buttons each pass through a 2-flop synchroniser.
- A rising edge on a synchronised button sets its sticky bit.

FSM:
- IDLE -> ACCESS when req = 1. addr, we, size, sign and wdata are latched.
- ACCESS -> RESP unconditionally. The synchronous RAM read or write, or the I/O register write, happens on this edge.
- RESP -> IDLE. ack = 1, rdata and err are driven; a sticky-register read clears the register on this edge.
- req is ignored outside IDLE.

## Timing
- Latency: req sampled at edge N gives ack high during the cycle after edge N+2. A new req can be accepted at edge N+3, so throughput is one access per 3 cycles.
- ack, err and the rdata update are registered. rdata holds its value until the next RESP.
- On a sticky read-clear, a new edge in the same cycle wins: the bit stays set.
- A switch change is visible to loads 2 cycles after it settles.
- Reset values:
  - FSM = IDLE; ack = 0, err = 0, rdata = 0.
  - led_out = 0; sticky = 0; all synchroniser flops = 0.
  - RAM contents are not reset.
- Reset mid-operation aborts the access. A store not yet past the ACCESS edge is not performed, and no ack is issued.

## Test plan
- Store word 0x11223344 to 0x10, store byte 0xAA to 0x12, load word from 0x10 -> 0x11AA3344, ack exactly 3 cycles after req, err = 0.
- Load from 0x10 with half signed at 0x12, byte signed at 0x12 and byte unsigned at 0x12 -> 0x000011AA, 0xFFFFFFAA, 0x000000AA.
- Store word to 0x13, then half to 0x11, then size = 3 -> err = 1 on each and RAM unchanged; store to DEPTH_WORDS*4 + 0x10 -> aliases 0x10.
- Store half 0xBEEF to 0x80000004 -> led_out[31:16] = 0xBEEF; sw_in[15:0] = 0x5A5A, wait 3 cycles, load half 0x80000040 -> 0x5A5A; access to 0x800000F0 -> err = 1.
- Pulse btn_in[2] for 4 cycles -> load 0x80000084 returns 0x4, second read returns 0; an edge coinciding with the clearing read remains set.
- Assert rst during ACCESS of a store to 0x20 -> ack never pulses, outputs return to 0, and a later load of 0x20 returns the old data.

Source files
------------

// File: rtl/data_mem_io.sv
// Byte-lane data RAM plus memory-mapped LED/switch/button registers behind a req/ack handshake.
// Fixed three-state access (ack two edges after req is taken); req is ignored while busy.
module data_mem_io #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LED_CH      = 2,
    parameter int SW_CH       = 2,
    parameter int BTN_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic                  err,
    input  logic [SW_CH*16-1:0]   sw_in,
    input  logic [BTN_W-1:0]      btn_in,
    output logic [LED_CH*16-1:0]  led_out
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d, sign_q, sign_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d, err_q, err_d;

    logic [LED_CH-1:0][15:0] led_q, led_d;
    logic [SW_CH-1:0][15:0]  sw_s1_q, sw_s2_q;
    logic [BTN_W-1:0]        btn_s1_q, btn_s2_q, btn_prev_q, sticky_q, sticky_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_rd_q;

    logic        is_io, misalign, io_hit, err_c, ram_we, stk_clr;
    logic [1:0]  io_grp;
    logic [3:0]  io_idx, be;
    logic [31:0] wd, io_raw, raw, ld;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        unused_addr;

    // Bits above the RAM index only alias; they never select anything.
    assign unused_addr = ^addr_q[30:AW+2];

    always_comb begin
        is_io    = addr_q[31];
        io_grp   = addr_q[7:6];
        io_idx   = addr_q[5:2];
        misalign = (size_q == 2'd3) || (size_q == 2'd1 && addr_q[0]) ||
                   (size_q == 2'd2 && addr_q[1:0] != 2'b00);
        io_hit   = 1'b0;
        io_raw   = '0;
        for (int i = 0; i < LED_CH; i++) begin
            if (io_grp == 2'b00 && io_idx == 4'(i)) begin
                io_hit = 1'b1;
                io_raw = {16'h0, led_q[i]};
            end
        end
        for (int i = 0; i < SW_CH; i++) begin
            if (io_grp == 2'b01 && io_idx == 4'(i)) begin
                io_hit = 1'b1;
                io_raw = {16'h0, sw_s2_q[i]};
            end
        end
        if (io_grp == 2'b10 && io_idx == 4'h0) begin
            io_hit = 1'b1;
            io_raw = 32'(btn_s2_q);
        end
        if (io_grp == 2'b10 && io_idx == 4'h1) begin
            io_hit = 1'b1;
            io_raw = 32'(sticky_q);
        end
        err_c = misalign || (is_io && !io_hit);

        be = 4'hf;
        wd = wdata_q;
        case (size_q)
            2'd0: begin be = 4'b0001 << addr_q[1:0];          wd = {4{wdata_q[7:0]}};  end
            2'd1: begin be = addr_q[1] ? 4'b1100 : 4'b0011;   wd = {2{wdata_q[15:0]}}; end
            default: ;
        endcase
        ram_we = (state_q == ACCESS) && we_q && !is_io && !err_c;

        raw  = is_io ? io_raw : ram_rd_q;
        ld_b = raw[{addr_q[1:0], 3'b000} +: 8];
        ld_h = addr_q[1] ? raw[31:16] : raw[15:0];
        case (size_q)
            2'd0:    ld = {{24{sign_q & ld_b[7]}}, ld_b};
            2'd1:    ld = {{16{sign_q & ld_h[15]}}, ld_h};
            default: ld = raw;
        endcase
        stk_clr = (state_q == RESP) && is_io && io_grp == 2'b10 && io_idx == 4'h1 &&
                  !we_q && !err_c;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        sign_d   = sign_q;
        size_d   = size_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        led_d    = led_q;
        // A fresh edge in the clearing cycle survives the clear.
        sticky_d = (sticky_q & ~{BTN_W{stk_clr}}) | (btn_s2_q & ~btn_prev_q);
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    sign_d  = sign;
                    size_d  = size;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (we_q && is_io && !err_c) begin
                    for (int i = 0; i < LED_CH; i++) begin
                        if (io_grp == 2'b00 && io_idx == 4'(i)) begin
                            if (be[0]) led_d[i][7:0]  = wd[7:0];
                            if (be[1]) led_d[i][15:8] = wd[15:8];
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                ack_d   = 1'b1;
                err_d   = err_c;
                rdata_d = (err_c || we_q) ? 32'h0 : ld;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            size_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            led_q      <= '0;
            sticky_q   <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            sign_q     <= sign_d;
            size_q     <= size_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            sticky_q   <= sticky_d;
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= btn_in;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
        end
    end

    // RAM has no reset; reset forces IDLE so an in-flight store never writes.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS) ram_rd_q <= mem[addr_q[AW+1:2]];
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    assign rdata   = rdata_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign led_out = led_q;
endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: RAM lanes, alignment errors, aliasing, I/O map, buttons, reset abort.
module tb_data_mem_io;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        ack, err;
    logic [31:0] sw_in = '0;
    logic [4:0]  btn_in = '0;
    logic [31:0] led_out;

    int n_assert = 0;
    int n_fail   = 0;

    data_mem_io #(.DEPTH_WORDS(4096), .LED_CH(2), .SW_CH(2), .BTN_W(5)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
        .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one access and check latency, err and (for loads/errors) rdata.
    task automatic acc(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!ack && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!w || exp_err) chk({tag, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin
        int acks;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_led", led_out, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // RAM lanes and extension
        acc("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0);
        acc("sb12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 1'b0, 32'h0);
        acc("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11AA3344);
        @(posedge clk); #1;
        chk("ack_pulse", 32'(ack), 32'd0);
        acc("lh12s", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000011AA);
        acc("lb12s", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFFFAA);
        acc("lb12u", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b0, 32'h000000AA);

        // Misalignment / illegal size leave RAM untouched
        acc("sw13", 1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0);
        acc("sh11", 1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFFFFFF, 1'b1, 32'h0);
        acc("sz3", 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0);
        acc("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11AA3344);

        // Aliasing past the RAM depth
        acc("swalias", 1'b1, 2'd2, 1'b0, 32'h4010, 32'hCAFEF00D, 1'b0, 32'h0);
        acc("lwalias", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D);

        // LED registers
        acc("shled", 1'b1, 2'd1, 1'b0, 32'h80000004, 32'h0000BEEF, 1'b0, 32'h0);
        chk("led1", led_out, 32'hBEEF0000);
        acc("sbled2", 1'b1, 2'd0, 1'b0, 32'h80000006, 32'h00000055, 1'b0, 32'h0);
        chk("led_lane2", led_out, 32'hBEEF0000);
        acc("lwled", 1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 1'b0, 32'h0000BEEF);
        acc("lhleds", 1'b0, 2'd1, 1'b1, 32'h80000004, 32'h0, 1'b0, 32'hFFFFBEEF);

        // Switches, read-only store, unmapped
        sw_in = 32'h00005A5A;
        repeat (3) @(posedge clk);
        #1;
        acc("lhsw", 1'b0, 2'd1, 1'b0, 32'h80000040, 32'h0, 1'b0, 32'h00005A5A);
        acc("stsw", 1'b1, 2'd2, 1'b0, 32'h80000040, 32'h12345678, 1'b0, 32'h0);
        acc("lwsw", 1'b0, 2'd2, 1'b0, 32'h80000040, 32'h0, 1'b0, 32'h00005A5A);
        acc("unmap", 1'b0, 2'd2, 1'b0, 32'h800000F0, 32'h0, 1'b1, 32'h0);

        // Sticky button edges
        btn_in = 5'b00100;
        repeat (4) @(posedge clk);
        #1 btn_in = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        acc("stk1", 1'b0, 2'd2, 1'b0, 32'h80000084, 32'h0, 1'b0, 32'h00000004);
        acc("stk2", 1'b0, 2'd2, 1'b0, 32'h80000084, 32'h0, 1'b0, 32'h00000000);
        btn_in = 5'b00001;
        acc("stk3", 1'b0, 2'd2, 1'b0, 32'h80000084, 32'h0, 1'b0, 32'h00000000);
        acc("stk4", 1'b0, 2'd2, 1'b0, 32'h80000084, 32'h0, 1'b0, 32'h00000001);
        acc("btnlvl", 1'b0, 2'd2, 1'b0, 32'h80000080, 32'h0, 1'b0, 32'h00000001);
        btn_in = 5'b00000;

        // Reset while a store sits in ACCESS
        acc("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0);
        acc("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);
        req = 1'b1; we = 1'b1; size = 2'd2; sign = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_led", led_out, 32'h0);
        acks = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("abort_noack", 32'(acks), 32'd0);
        acc("lw20post", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
